// File: rtl/stretch_frame_ctrl_if.sv
// stretch_frame_ctrl_if: pixel-in, frame RAM, divider and read-out signals of the frame scheduler
interface stretch_frame_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
);
  logic                    pix_valid;
  logic [DATA_WIDTH-1:0]   pix_data;
  logic                    pix_ready;
  logic                    ram_we;
  logic [ADDRESS_WIDTH:0]  ram_waddr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic                    ram_re;
  logic [ADDRESS_WIDTH:0]  ram_raddr;
  logic                    div_start;
  logic [DATA_WIDTH-1:0]   div_divisor;
  logic                    div_done;
  logic [DATA_WIDTH-1:0]   div_quotient;
  logic                    rd_ready;
  logic                    rd_valid;
  logic                    rd_last;
  logic [DATA_WIDTH-1:0]   gain;
  logic [DATA_WIDTH-1:0]   min_pix;
  modport master (
    output pix_valid, pix_data, div_done, div_quotient, rd_ready,
    input  pix_ready, ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
           div_start, div_divisor, rd_valid, rd_last, gain, min_pix
  );
  modport slave (
    input  pix_valid, pix_data, div_done, div_quotient, rd_ready,
    output pix_ready, ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
           div_start, div_divisor, rd_valid, rd_last, gain, min_pix
  );
endinterface

// File: rtl/stretch_frame_ctrl.sv
// stretch_frame_ctrl: ping-pong frame writer with min/max tracking and gain/read-out scheduler
module stretch_frame_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input logic               clk,
  input logic               rstn,
  stretch_frame_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, WAIT, READ} state_t;
  state_t                         state_q, state_d;
  logic                           wbank_q, wbank_d, rbank_q, rbank_d;
  logic [ADDRESS_WIDTH-1:0]       wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [DATA_WIDTH-1:0]          run_max_q, run_max_d, run_min_q, run_min_d;
  logic [1:0]                     full_q, full_d;
  logic [1:0][DATA_WIDTH-1:0]     bmax_q, bmax_d, bmin_q, bmin_d;
  logic [DATA_WIDTH-1:0]          gain_q, gain_d, min_pix_q, min_pix_d;
  logic [DATA_WIDTH-1:0]          div_divisor_q, div_divisor_d;
  logic                           rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic                           xfer, w_last, r_issue, r_last;
  logic [DATA_WIDTH-1:0]          pix_max, pix_min, cur_max, cur_min;
  // writer: address generation, running statistics and bank hand-off on the last pixel
  always_comb begin
    xfer      = bus.pix_valid & !full_q[wbank_q];
    w_last    = xfer & (wcnt_q == '1);
    pix_max   = (bus.pix_data > run_max_q) ? bus.pix_data : run_max_q;
    pix_min   = (bus.pix_data < run_min_q) ? bus.pix_data : run_min_q;
    wbank_d   = wbank_q ^ w_last;
    wcnt_d    = wcnt_q + ADDRESS_WIDTH'(xfer);
    run_max_d = w_last ? '0 : xfer ? pix_max : run_max_q;
    run_min_d = w_last ? '1 : xfer ? pix_min : run_min_q;
    bmax_d    = bmax_q;
    bmin_d    = bmin_q;
    if (w_last) begin
      bmax_d[wbank_q] = pix_max;
      bmin_d[wbank_q] = pix_min;
    end
  end
  // scheduler: gain calculation then read-out of the bank at rbank; full flags merge both sides
  always_comb begin
    cur_max       = bmax_q[rbank_q];
    cur_min       = bmin_q[rbank_q];
    state_d       = state_q;
    gain_d        = gain_q;
    min_pix_d     = min_pix_q;
    div_divisor_d = div_divisor_q;
    bus.div_start = 1'b0;
    r_issue       = (state_q == READ) & bus.rd_ready;
    r_last        = r_issue & (rcnt_q == '1);
    rcnt_d        = rcnt_q + ADDRESS_WIDTH'(r_issue);
    rbank_d       = rbank_q ^ r_last;
    case (state_q)
      IDLE: state_d = full_q[rbank_q] ? CALC : IDLE;
      CALC: begin
        if (cur_max == cur_min) begin
          gain_d    = DATA_WIDTH'(1);
          min_pix_d = cur_min;
          state_d   = READ;
        end else begin
          bus.div_start = 1'b1;
          div_divisor_d = cur_max - cur_min;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (bus.div_done) begin
          gain_d    = bus.div_quotient;
          min_pix_d = cur_min;
          state_d   = READ;
        end
      end
      READ: state_d = r_last ? IDLE : READ;
      default: state_d = IDLE;
    endcase
    full_d = full_q;
    if (r_last) full_d[rbank_q] = 1'b0;
    if (w_last) full_d[wbank_q] = 1'b1;
    rd_valid_d = r_issue;
    rd_last_d  = r_last;
  end
  // all registered state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      wbank_q       <= 1'b0;
      rbank_q       <= 1'b0;
      wcnt_q        <= '0;
      rcnt_q        <= '0;
      run_max_q     <= '0;
      run_min_q     <= '1;
      full_q        <= '0;
      bmax_q        <= '0;
      bmin_q        <= '0;
      gain_q        <= '0;
      min_pix_q     <= '0;
      div_divisor_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_last_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wbank_q       <= wbank_d;
      rbank_q       <= rbank_d;
      wcnt_q        <= wcnt_d;
      rcnt_q        <= rcnt_d;
      run_max_q     <= run_max_d;
      run_min_q     <= run_min_d;
      full_q        <= full_d;
      bmax_q        <= bmax_d;
      bmin_q        <= bmin_d;
      gain_q        <= gain_d;
      min_pix_q     <= min_pix_d;
      div_divisor_q <= div_divisor_d;
      rd_valid_q    <= rd_valid_d;
      rd_last_q     <= rd_last_d;
    end
  end
  assign bus.pix_ready   = !full_q[wbank_q];
  assign bus.ram_we      = xfer;
  assign bus.ram_waddr   = {wbank_q, wcnt_q};
  assign bus.ram_wdata   = bus.pix_data;
  assign bus.ram_re      = r_issue;
  assign bus.ram_raddr   = {rbank_q, rcnt_q};
  assign bus.div_divisor = div_divisor_d;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_last     = rd_last_q;
  assign bus.gain        = gain_q;
  assign bus.min_pix     = min_pix_q;
endmodule
